// File: rtl/rotary_decoder.sv
// -----------------------------------------------------------------------------
// rotary_decoder : debounced quadrature encoder + push-switch decoder.
// Optional saturating position counter enabled by `define ROTARY_DECODER_POSITION_EN
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rotary_decoder #(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int POS_MAX        = 99
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SAMPLE_TICK,
  input  logic       ENC_A,
  input  logic       ENC_B,
  input  logic       ENC_SW,
  output logic       STEP,
  output logic       DIR,
  output logic       SW_LEVEL,
  output logic       SW_PRESS,
  output logic [7:0] POSITION
);

  if (DEBOUNCE_TICKS < 2 || DEBOUNCE_TICKS > 15) begin : g_bad_debounce
    $error("rotary_decoder: DEBOUNCE_TICKS out of range 2..15");
  end
  if (POS_MAX < 1 || POS_MAX > 255) begin : g_bad_pos_max
    $error("rotary_decoder: POS_MAX out of range 1..255");
  end

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CW1  = 3'd1,
    CW2  = 3'd2,
    CW3  = 3'd3,
    CCW1 = 3'd4,
    CCW2 = 3'd5,
    CCW3 = 3'd6
  } state_t;

  // Bit order everywhere: [0]=A, [1]=B, [2]=SW
  logic [2:0] raw_in;
  logic [2:0] sync_q1;
  logic [2:0] sync_q2;
  logic [2:0] filt;
  logic [3:0] cnt [3];
  logic [1:0] ab;
  state_t     state;
  logic       sw_level_q;

  assign raw_in = {ENC_SW, ENC_B, ENC_A};
  assign ab     = {filt[0], filt[1]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  // A filtered bit flips only after DEBOUNCE_TICKS consecutive differing ticks.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt <= '1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else if (SAMPLE_TICK) begin
      for (int i = 0; i < 3; i++) begin
        if (sync_q2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          filt[i] <= sync_q2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      STEP  <= 1'b0;
      DIR   <= 1'b0;
    end else begin
      STEP <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ab == 2'b01)      state <= CW1;
          else if (ab == 2'b10) state <= CCW1;
        end
        CW1: begin
          if (ab == 2'b00)      state <= CW2;
          else if (ab == 2'b11) state <= IDLE;
        end
        CW2: begin
          if (ab == 2'b10)      state <= CW3;
          else if (ab == 2'b01) state <= CW1;
        end
        CW3: begin
          if (ab == 2'b11) begin
            state <= IDLE;
            STEP  <= 1'b1;
            DIR   <= 1'b0;
          end else if (ab == 2'b00) begin
            state <= CW2;
          end
        end
        CCW1: begin
          if (ab == 2'b00)      state <= CCW2;
          else if (ab == 2'b11) state <= IDLE;
        end
        CCW2: begin
          if (ab == 2'b01)      state <= CCW3;
          else if (ab == 2'b10) state <= CCW1;
        end
        CCW3: begin
          if (ab == 2'b11) begin
            state <= IDLE;
            STEP  <= 1'b1;
            DIR   <= 1'b1;
          end else if (ab == 2'b00) begin
            state <= CCW2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SW_LEVEL = ~filt[2];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_level_q <= 1'b0;
      SW_PRESS   <= 1'b0;
    end else begin
      sw_level_q <= SW_LEVEL;
      SW_PRESS   <= SW_LEVEL & ~sw_level_q;
    end
  end

`ifdef ROTARY_DECODER_POSITION_EN
  localparam logic [7:0] POS_LIM = 8'(POS_MAX);

  // Switch clear takes precedence over a coincident step.
  always_ff @(posedge CLK) begin
    if (RESET || SW_PRESS) begin
      POSITION <= '0;
    end else if (STEP) begin
      if (!DIR) begin
        if (POSITION != POS_LIM) POSITION <= POSITION + 8'd1;
      end else begin
        if (POSITION != 8'd0) POSITION <= POSITION - 8'd1;
      end
    end
  end
`else
  assign POSITION = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rotary_decoder.sv
// -----------------------------------------------------------------------------
// tb_rotary_decoder : directed scoreboard bench for rotary_decoder.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_rotary_decoder;

  localparam int DB       = 5;
  localparam int PMAX     = 99;
  localparam int TICK_DIV = 4;
`ifdef ROTARY_DECODER_POSITION_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SAMPLE_TICK = 1'b0;
  logic       ENC_A = 1'b1;
  logic       ENC_B = 1'b1;
  logic       ENC_SW = 1'b1;
  logic       STEP;
  logic       DIR;
  logic       SW_LEVEL;
  logic       SW_PRESS;
  logic [7:0] POSITION;

  int total = 0;
  int bad = 0;
  int steps_seen = 0;
  int steps_exp = 0;
  int press_seen = 0;
  int exp_pos = 0;
  bit exp_dir_q[$];

  rotary_decoder #(.DEBOUNCE_TICKS(DB), .POS_MAX(PMAX)) dut (
    .CLK(CLK), .RESET(RESET), .SAMPLE_TICK(SAMPLE_TICK),
    .ENC_A(ENC_A), .ENC_B(ENC_B), .ENC_SW(ENC_SW),
    .STEP(STEP), .DIR(DIR), .SW_LEVEL(SW_LEVEL), .SW_PRESS(SW_PRESS),
    .POSITION(POSITION)
  );

  always #5 CLK = ~CLK;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge CLK);
      div = (div == TICK_DIV - 1) ? 0 : div + 1;
      SAMPLE_TICK = (div == 0);
    end
  end

  // Scoreboard: every STEP pulse consumes one expected direction.
  initial begin : step_mon
    bit e;
    forever begin
      @(negedge CLK);
      if (STEP === 1'b1) begin
        steps_seen++;
        total++;
        assert (exp_dir_q.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_step observed=STEP expected=none queued");
        end
        if (exp_dir_q.size() > 0) begin
          e = exp_dir_q.pop_front();
          total++;
          assert (DIR === e) else begin
            bad++;
            $error("FAIL step_dir observed=%b expected=%b", DIR, e);
          end
        end
      end
      if (SW_PRESS === 1'b1) press_seen++;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * TICK_DIV) @(negedge CLK);
  endtask

  task automatic set_ab(input logic a, input logic b, input int ticks);
    ENC_A = a;
    ENC_B = b;
    wait_ticks(ticks);
  endtask

  task automatic detent(input bit ccw, input int hold);
    exp_dir_q.push_back(ccw);
    steps_exp++;
    if (!ccw) exp_pos = (exp_pos == PMAX) ? PMAX : exp_pos + 1;
    else      exp_pos = (exp_pos == 0) ? 0 : exp_pos - 1;
    if (!ccw) begin
      set_ab(1'b0, 1'b1, hold);
      set_ab(1'b0, 1'b0, hold);
      set_ab(1'b1, 1'b0, hold);
    end else begin
      set_ab(1'b1, 1'b0, hold);
      set_ab(1'b0, 1'b0, hold);
      set_ab(1'b0, 1'b1, hold);
    end
    set_ab(1'b1, 1'b1, hold);
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int pos_exp();
    return POS_EN ? exp_pos : 0;
  endfunction

  initial begin : main
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_step", int'(STEP), 0);
    chk("rst_dir", int'(DIR), 0);
    chk("rst_sw_level", int'(SW_LEVEL), 0);
    chk("rst_sw_press", int'(SW_PRESS), 0);
    chk("rst_position", int'(POSITION), 0);
    RESET = 1'b0;
    wait_ticks(3);

    // Clockwise then two counter-clockwise detents
    detent(1'b0, 8);
    chk("cw_steps", steps_seen, steps_exp);
    chk("cw_dir", int'(DIR), 0);
    chk("cw_position", int'(POSITION), pos_exp());
    detent(1'b1, 8);
    chk("ccw_dir", int'(DIR), 1);
    chk("ccw_position", int'(POSITION), pos_exp());
    detent(1'b1, 8);
    chk("ccw_floor_position", int'(POSITION), pos_exp());
    chk("ccw_steps", steps_seen, steps_exp);

    // Short A glitch at IDLE
    set_ab(1'b0, 1'b1, 3);
    set_ab(1'b1, 1'b1, 8);
    chk("glitch_idle_steps", steps_seen, steps_exp);

    // At CW3, a 4-tick return to 11 must be filtered out
    exp_dir_q.push_back(1'b0);
    steps_exp++;
    exp_pos = exp_pos + 1;
    set_ab(1'b0, 1'b1, 8);
    set_ab(1'b0, 1'b0, 8);
    set_ab(1'b1, 1'b0, 8);
    set_ab(1'b1, 1'b1, DB - 1);
    set_ab(1'b1, 1'b0, 8);
    chk("glitch_cw3_steps", steps_seen, steps_exp - 1);
    set_ab(1'b1, 1'b1, 8);
    chk("glitch_cw3_done", steps_seen, steps_exp);

    // Each phase held exactly DEBOUNCE_TICKS ticks is still accepted
    detent(1'b0, DB);
    wait_ticks(4);
    chk("min_hold_steps", steps_seen, steps_exp);
    chk("min_hold_position", int'(POSITION), pos_exp());

    // Partial turn reversed
    set_ab(1'b0, 1'b1, 8);
    set_ab(1'b1, 1'b1, 8);
    chk("partial_steps", steps_seen, steps_exp);

    // Saturation at POS_MAX
    for (int i = 0; i < 100; i++) detent(1'b0, 6);
    wait_ticks(2);
    chk("sat_steps", steps_seen, steps_exp);
    chk("sat_position", int'(POSITION), POS_EN ? PMAX : 0);

    // Switch press clears position
    ENC_SW = 1'b0;
    wait_ticks(10);
    exp_pos = 0;
    chk("sw_level_pressed", int'(SW_LEVEL), 1);
    chk("sw_press_count", press_seen, 1);
    chk("sw_position", int'(POSITION), pos_exp());
    ENC_SW = 1'b1;
    wait_ticks(10);
    chk("sw_level_released", int'(SW_LEVEL), 0);
    chk("sw_release_press_count", press_seen, 1);

    // Reset in CW2 with DIR=1 and nonzero position
    detent(1'b0, 6);
    detent(1'b0, 6);
    detent(1'b1, 6);
    chk("pre_rst_dir", int'(DIR), 1);
    chk("pre_rst_position", int'(POSITION), pos_exp());
    set_ab(1'b0, 1'b1, 8);
    set_ab(1'b0, 1'b0, 8);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("mid_rst_dir", int'(DIR), 0);
    chk("mid_rst_step", int'(STEP), 0);
    chk("mid_rst_position", int'(POSITION), 0);
    chk("mid_rst_sw_level", int'(SW_LEVEL), 0);
    RESET = 1'b0;
    exp_pos = 0;
    set_ab(1'b0, 1'b0, 8);
    set_ab(1'b1, 1'b0, 8);
    set_ab(1'b1, 1'b1, 8);
    chk("post_rst_steps", steps_seen, steps_exp);
    chk("post_rst_queue", exp_dir_q.size(), 0);
    detent(1'b0, 8);
    chk("post_rst_detent_steps", steps_seen, steps_exp);
    chk("post_rst_position", int'(POSITION), pos_exp());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rotary_decoder.md
ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 5: consecutive stable SAMPLE_TICK samples required before a filtered input changes (legal 2..15).
REQ-002 Parameter POS_MAX, default 99: upper bound of POSITION (legal 1..255).
REQ-003 CLK  input  1  single system clock; all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 SAMPLE_TICK  input  1  one-CLK-wide debounce strobe (1 kHz divider trigger).
REQ-006 ENC_A  input  1  raw encoder channel A, asynchronous, idle high at detent.
REQ-007 ENC_B  input  1  raw encoder channel B, asynchronous, idle high at detent.
REQ-008 ENC_SW  input  1  raw push switch, asynchronous, active low.
REQ-009 STEP  output  1  one-CLK pulse per completed detent.
REQ-010 DIR  output  1  direction of last completed detent; 0 = clockwise/up, 1 = counter-clockwise/down.
REQ-011 SW_LEVEL  output  1  debounced switch, active high (1 = pressed).
REQ-012 SW_PRESS  output  1  one-CLK pulse on debounced press edge.
REQ-013 POSITION  output  8  saturating detent position (present only per REQ-034).

Function
REQ-014 ENC_A, ENC_B, ENC_SW each pass a 2-flop synchroniser before any other use.
REQ-015 Each synchronised input feeds its own debounce filter: 4-bit stability counter, evaluated only on SAMPLE_TICK cycles.
REQ-016 On SAMPLE_TICK: sync value equal to filtered value -> counter cleared; otherwise counter increments; counter reaching DEBOUNCE_TICKS-1 at that tick -> filtered value takes sync value, counter cleared.
REQ-017 Filtered values never change on non-tick cycles; a glitch shorter than DEBOUNCE_TICKS ticks produces no change.
REQ-018 Quadrature FSM on filtered {A,B}, 7 states: IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3.
REQ-019 IDLE: {A,B}=01 -> CW1; 10 -> CCW1; 11 or 00 -> stay.
REQ-020 CW1: 00 -> CW2; 11 -> IDLE; 01 stay; 10 stay (illegal double change).
REQ-021 CW2: 10 -> CW3; 01 -> CW1; 00 stay; 11 stay.
REQ-022 CW3: 11 -> IDLE with STEP=1, DIR=0; 00 -> CW2; 10 stay; 01 stay.
REQ-023 CCW1/CCW2/CCW3 mirror REQ-020..022 with 01 and 10 swapped; CCW3 -> IDLE on 11 emits STEP=1, DIR=1.
REQ-024 STEP is registered: asserted exactly one CLK, the cycle after the FSM takes the completing transition.
REQ-025 DIR updates in the same cycle STEP asserts and holds until the next STEP.
REQ-026 Return to IDLE from CW1/CCW1 (partial turn reversed) emits no STEP.
REQ-027 SW_LEVEL equals inverted filtered ENC_SW; SW_PRESS asserts one CLK, the cycle after SW_LEVEL rises; release emits nothing.
REQ-028 STEP and SW_PRESS may assert in the same cycle; independent.
REQ-029 Total latency raw edge -> STEP: 2 sync cycles + DEBOUNCE_TICKS ticks + 2 CLK, deterministic.

Reset
REQ-030 RESET takes priority over all other inputs in the same cycle.
REQ-031 On RESET: synchronisers and filtered A/B/SW = 1, debounce counters = 0, FSM = IDLE, STEP = 0, DIR = 0, SW_PRESS = 0, SW_LEVEL = 0, POSITION = 0.
REQ-032 RESET asserted mid-rotation abandons the partial sequence; no STEP emitted after release until a full new detent completes.

Configuration
REQ-033 Macro ROTARY_DECODER_POSITION_EN selects the position counter.
REQ-034 Defined: POSITION increments on STEP with DIR=0, decrements on STEP with DIR=1, saturates at POS_MAX and 0 (no wrap); SW_PRESS clears POSITION to 0, clear wins over a simultaneous STEP.
REQ-035 Undefined: no position register synthesised; POSITION driven constant 0; all other behaviour identical.

Verification
REQ-036 Clockwise detent 11->01->00->10->11, each held 8 ticks, DEBOUNCE_TICKS=5 -> exactly one STEP pulse, DIR=0, POSITION 0->1.
REQ-037 Counter-clockwise detent 11->10->00->01->11 from POSITION=1 -> one STEP, DIR=1, POSITION 0; repeat -> STEP, POSITION stays 0.
REQ-038 ENC_A glitch low for 3 ticks at IDLE -> no FSM state change, no STEP.
REQ-039 Partial turn 11->01->11 -> FSM returns IDLE, zero STEP; 100 clockwise detents with POS_MAX=99 -> POSITION 99.
REQ-040 ENC_SW low 10 ticks -> SW_LEVEL=1, single SW_PRESS, POSITION cleared to 0; RESET asserted at CW2 -> IDLE, all outputs at reset values, no STEP after release.
